// File: rtl/ysyx_22050039_lsu_if.sv
// Signal bundle between the LSU, the execute/writeback stages and the data-memory bus.
// Handshake rule for every channel (in_*, out_*, mem_req_*, mem_resp_*): a transfer happens on the
// rising edge where valid && ready; the source holds valid and payload stable until then, and ready
// never depends combinationally on valid. mem_resp has no ready: the LSU always sinks it in WAIT.
`timescale 1ns/1ps
interface ysyx_22050039_lsu_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic [REG_AW-1:0] out_rd;
  logic              out_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  // The LSU side.
  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata
  );

  // The pipeline and memory side.
  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one op in flight, aligns stores onto 8-byte bus lanes and extends load data.
// State is exposed on dbg_state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE).
`timescale 1ns/1ps
module ysyx_22050039_lsu #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22050039_lsu_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state, state_next;

  logic              req_we_q;
  logic [XLEN-1:0]   req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [7:0]        req_wmask_q;
  logic [XLEN-1:0]   out_rdata_q;
  logic [REG_AW-1:0] out_rd_q;
  logic              out_err_q;
  logic [2:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic              misaligned;
  logic [7:0]        size_mask;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (bus.in_op[1:0])
      2'd0: begin misaligned = 1'b0;                      size_mask = 8'h01; end
      2'd1: begin misaligned = bus.in_addr[0];            size_mask = 8'h03; end
      2'd2: begin misaligned = |bus.in_addr[1:0];         size_mask = 8'h0f; end
      default: begin misaligned = |bus.in_addr[2:0];      size_mask = 8'hff; end
    endcase
  end

  // Bring the addressed bytes down to bit 0, then sign/zero extend by size.
  always_comb begin
    shifted  = bus.mem_resp_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = {{(XLEN-8){shifted[7] & ~uns_q}}, shifted[7:0]};
      2'd1: load_ext = {{(XLEN-16){shifted[15] & ~uns_q}}, shifted[15:0]};
      2'd2: load_ext = {{(XLEN-32){shifted[31] & ~uns_q}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.mem_req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = misaligned ? S_DONE : S_REQ;
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_next = req_we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) state_next = S_DONE;
      end
      default: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = S_IDLE;
      end
    endcase
  end

  // Request fields are captured at accept so they stay frozen for the whole REQ stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= 8'h00;
      out_rdata_q <= '0;
      out_rd_q    <= '0;
      out_err_q   <= 1'b0;
      off_q       <= 3'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            req_we_q    <= bus.in_op[3];
            req_addr_q  <= {bus.in_addr[XLEN-1:3], 3'b000};
            req_wdata_q <= bus.in_wdata << {bus.in_addr[2:0], 3'b000};
            req_wmask_q <= bus.in_op[3] ? (size_mask << bus.in_addr[2:0]) : 8'h00;
            out_rdata_q <= '0;
            out_rd_q    <= bus.in_op[3] ? '0 : bus.in_rd;
            out_err_q   <= misaligned;
            off_q       <= bus.in_addr[2:0];
            size_q      <= bus.in_op[1:0];
            uns_q       <= bus.in_op[2] & ~bus.in_op[3];
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) out_rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_err       = out_err_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for ysyx_22050039_lsu: a vector table of single ops plus hand-written
// stall and reset-in-flight sequences.
`timescale 1ns/1ps
module tb_ysyx_22050039_lsu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_22050039_lsu_if bus ();

  ysyx_22050039_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] resp;
    logic [63:0] e_rdata;
    logic [4:0]  e_rd;
    logic        e_err;
    logic        e_we;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wmask;
    int          e_lat;
  } vec_t;

  vec_t vt[$];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"},     64'(bus.out_valid),     64'd0);
    chk({tag, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    chk({tag, " out_err"},       64'(bus.out_err),       64'd0);
    chk({tag, " out_rdata"},     bus.out_rdata,          64'd0);
    chk({tag, " out_rd"},        64'(bus.out_rd),        64'd0);
    chk({tag, " mem_req_we"},    64'(bus.mem_req_we),    64'd0);
    chk({tag, " mem_req_addr"},  bus.mem_req_addr,       64'd0);
    chk({tag, " mem_req_wdata"}, bus.mem_req_wdata,      64'd0);
    chk({tag, " mem_req_wmask"}, 64'(bus.mem_req_wmask), 64'd0);
    chk({tag, " in_ready"},      64'(bus.in_ready),      64'd1);
    chk({tag, " state"},         64'(dbg_state),         64'd0);
  endtask

  // ---------------- driver ----------------
  // Memory answers immediately: req_ready and resp_valid are held high for the whole op,
  // which also exercises that they are ignored outside REQ / WAIT.
  task automatic run_vec(input vec_t v, input string tag);
    bit seen_req;
    bit done;
    seen_req = 1'b0;
    done     = 1'b0;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid       = 1'b1;
    bus.in_op          = v.op;
    bus.in_addr        = v.addr;
    bus.in_wdata       = v.wdata;
    bus.in_rd          = v.rd;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = v.resp;
    bus.out_ready      = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_req_valid && !seen_req) begin
        seen_req = 1'b1;
        chk({tag, " req_addr"},  bus.mem_req_addr,       v.e_addr);
        chk({tag, " req_we"},    64'(bus.mem_req_we),    64'(v.e_we));
        chk({tag, " req_wmask"}, 64'(bus.mem_req_wmask), 64'(v.e_wmask));
        chk({tag, " req_wdata"}, bus.mem_req_wdata,      v.e_wdata);
      end
      if (bus.out_valid) begin
        chk({tag, " latency"},   64'(c),            64'(v.e_lat));
        chk({tag, " out_rdata"}, bus.out_rdata,     v.e_rdata);
        chk({tag, " out_rd"},    64'(bus.out_rd),   64'(v.e_rd));
        chk({tag, " out_err"},   64'(bus.out_err),  64'(v.e_err));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: got no out_valid expected within 20 cycles", tag);
    end
    chk({tag, " bus_traffic"}, 64'(seen_req), 64'(!v.e_err));
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t lwu;
    bus.in_valid       = 1'b0;
    bus.in_op          = 4'd0;
    bus.in_addr        = 64'd0;
    bus.in_wdata       = 64'd0;
    bus.in_rd          = 5'd0;
    bus.out_ready      = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;

    //            op      addr              wdata                  rd    resp                   e_rdata                e_rd  err we e_addr            e_wdata                e_wmask lat
    vt.push_back('{4'b0011, 64'h80000008, 64'h0,                 5'd5,  64'h1122334455667788, 64'h1122334455667788, 5'd5,  0, 0, 64'h80000008, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b0000, 64'h80000003, 64'h0,                 5'd7,  64'h0000000080000000, 64'hffffffffffffff80, 5'd7,  0, 0, 64'h80000000, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b0100, 64'h80000003, 64'h0,                 5'd8,  64'h0000000080000000, 64'h0000000000000080, 5'd8,  0, 0, 64'h80000000, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b1001, 64'h80000006, 64'habcd,              5'd9,  64'hdeaddeaddeaddead, 64'h0,                5'd0,  0, 1, 64'h80000000, 64'habcd000000000000, 8'hc0, 2});
    vt.push_back('{4'b0010, 64'h80000002, 64'h0,                 5'd3,  64'hffffffffffffffff, 64'h0,                5'd3,  1, 0, 64'h0,        64'h0,                 8'h00, 1});
    vt.push_back('{4'b0001, 64'h8000000e, 64'h0,                 5'd10, 64'h8001000000000000, 64'hffffffffffff8001, 5'd10, 0, 0, 64'h80000008, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b0101, 64'h8000000e, 64'h0,                 5'd11, 64'h8001000000000000, 64'h0000000000008001, 5'd11, 0, 0, 64'h80000008, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b0010, 64'h80000010, 64'h0,                 5'd12, 64'h0000000087654321, 64'hffffffff87654321, 5'd12, 0, 0, 64'h80000010, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b1000, 64'h80000005, 64'h123456789abcde5a,  5'd13, 64'h0,                64'h0,                5'd0,  0, 1, 64'h80000000, 64'hbcde5a0000000000, 8'h20, 2});
    vt.push_back('{4'b1010, 64'h80000004, 64'hdeadbeef,          5'd14, 64'h0,                64'h0,                5'd0,  0, 1, 64'h80000000, 64'hdeadbeef00000000, 8'hf0, 2});
    vt.push_back('{4'b1011, 64'h80000018, 64'h0123456789abcdef,  5'd15, 64'h0,                64'h0,                5'd0,  0, 1, 64'h80000018, 64'h0123456789abcdef, 8'hff, 2});
    vt.push_back('{4'b1011, 64'h80000004, 64'h1,                 5'd16, 64'h0,                64'h0,                5'd0,  1, 1, 64'h0,        64'h0,                 8'h00, 1});
    vt.push_back('{4'b0001, 64'h80000001, 64'h0,                 5'd17, 64'h0,                64'h0,                5'd17, 1, 0, 64'h0,        64'h0,                 8'h00, 1});
    vt.push_back('{4'b0111, 64'h80000028, 64'h0,                 5'd18, 64'h8000000000000001, 64'h8000000000000001, 5'd18, 0, 0, 64'h80000028, 64'h0,                 8'h00, 3});
    vt.push_back('{4'b1110, 64'h8000000c, 64'h00000000cafef00d,  5'd20, 64'h0,                64'h0,                5'd0,  0, 1, 64'h80000008, 64'hcafef00d00000000, 8'hf0, 2});
    vt.push_back('{4'b0010, 64'h80000004, 64'h0,                 5'd19, 64'h8000000000000000, 64'hffffffff80000000, 5'd19, 0, 0, 64'h80000000, 64'h0,                 8'h00, 3});

    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Table, applied back to back.
    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Stalled Lh: req_ready low 5 cycles, then out_ready low 3 cycles.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b0001;
    bus.in_addr  = 64'h8000000a;
    bus.in_wdata = 64'h0;
    bus.in_rd    = 5'd21;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall req_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("stall req_addr",  bus.mem_req_addr,       64'h80000008);
      chk("stall req_we",    64'(bus.mem_req_we),    64'd0);
      chk("stall req_wmask", 64'(bus.mem_req_wmask), 64'h00);
      chk("stall in_ready",  64'(bus.in_ready),      64'd0);
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("stall req_valid_drop", 64'(bus.mem_req_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h00000000f00d0000;
    @(posedge clk);
    #1 bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold out_rdata", bus.out_rdata,      64'hfffffffffffff00d);
      chk("hold out_rd",    64'(bus.out_rd),    64'd21);
      chk("hold in_ready",  64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("after_hs in_ready",  64'(bus.in_ready),  64'd1);
    chk("after_hs out_valid", 64'(bus.out_valid), 64'd0);

    // Reset while a load sits in WAIT, then a stray response.
    bus.in_valid      = 1'b1;
    bus.in_op         = 4'b0011;
    bus.in_addr       = 64'h80000020;
    bus.in_rd         = 5'd22;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst state", 64'(dbg_state), 64'd2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1111111111111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stray out_valid", 64'(bus.out_valid), 64'd0);
      chk("stray state",     64'(dbg_state),     64'd0);
    end
    bus.mem_resp_valid = 1'b0;

    lwu = '{4'b0110, 64'h80000004, 64'h0, 5'd23, 64'hfedcba9800000000, 64'h00000000fedcba98,
            5'd23, 0, 0, 64'h80000000, 64'h0, 8'h00, 3};
    run_vec(lwu, "post_rst_lwu");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
